konami_addr_decoder: RTL

Parametrised, registered CPU address decoder with per-region programmable wait states. Generalises the fixed PAL chip-select decoders on the arcade boards to N regions, each with its own base, mask and wait count. Adds a small FSM that latches each bus access, asserts exactly one active-low chip select, and returns a ready strobe to the CPU core. The block sits between the CPU bus and the ROM/RAM/IO chip-select fan-out.

---
 rtl/konami_dec_pkg.sv | 24 ++
 rtl/addr_match_prio.sv | 38 +++
 rtl/konami_addr_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/konami_dec_pkg.sv
// Shared types and helpers for the Konami-style programmable chip-select decoder.
// Holds the access FSM state encoding and the slicing helper for the packed cfg buses.
package konami_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } dec_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NREG_DEF = 8;
    localparam int IDXW     = idx_width(NREG_DEF);

    // Low bit of region i inside a flattened vector of w-bit fields.
    function automatic int slice_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/addr_match_prio.sv
// Combinational region matcher: compares the address against every base/mask pair
// and returns the lowest-numbered hitting region.
module addr_match_prio
    import konami_dec_pkg::*;
#(
    parameter int AW   = 16,
    parameter int NREG = 8,
    parameter int IW   = IDXW
) (
    input  logic [AW-1:0]      cpu_addr,
    input  logic [NREG*AW-1:0] cfg_base,
    input  logic [NREG*AW-1:0] cfg_mask,
    output logic               hit,
    output logic [IW-1:0]      idx
);

    logic [NREG-1:0] region_hit;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cmp
            assign region_hit[gi] =
                ((cpu_addr ^ cfg_base[slice_lo(gi, AW) +: AW]) & cfg_mask[slice_lo(gi, AW) +: AW]) == '0;
        end
    endgenerate

    // Scan from the top so the lowest hitting index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (region_hit[i]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/konami_addr_decoder.sv
// Registered CPU address decoder with per-region wait states: latches each bus
// access, drives one active-low chip select and returns a ready pulse to the CPU.
module konami_addr_decoder
    import konami_dec_pkg::*;
#(
    parameter int AW   = 16,
    parameter int NREG = 8,
    parameter int WSW  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       cpu_addr,
    input  logic                cpu_vma,
    input  logic [NREG*AW-1:0]  cfg_base,
    input  logic [NREG*AW-1:0]  cfg_mask,
    input  logic [NREG*WSW-1:0] cfg_wait,
    output logic [NREG-1:0]     cs_n,
    output logic                cpu_ready,
    output logic                miss,
    output logic                busy
);

    localparam int IW = idx_width(NREG);

    logic          match_hit;
    logic [IW-1:0] match_idx;

    addr_match_prio #(
        .AW   (AW),
        .NREG (NREG),
        .IW   (IW)
    ) u_match (
        .cpu_addr (cpu_addr),
        .cfg_base (cfg_base),
        .cfg_mask (cfg_mask),
        .hit      (match_hit),
        .idx      (match_idx)
    );

    logic [WSW-1:0] wait_arr [NREG];
    logic [WSW-1:0] wait_sel;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_wait
            assign wait_arr[gi] = cfg_wait[slice_lo(gi, WSW) +: WSW];
        end
    endgenerate

    assign wait_sel = wait_arr[match_idx];

    dec_state_t     state_q, state_d;
    logic [WSW-1:0] cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           hit_q, hit_d;
    logic [NREG-1:0] cs_n_q, cs_n_d;
    logic           ready_q, ready_d;
    logic           miss_q, miss_d;
    logic           busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hit_d   = hit_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_vma) begin
                    idx_d = match_idx;
                    hit_d = match_hit;
                    if (match_hit) begin
                        cnt_d   = wait_sel;
                        state_d = (wait_sel != '0) ? ST_WAIT : ST_ACK;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                // The count holds at 1 on the way out; it is only reloaded from IDLE.
                if (!cpu_vma) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= WSW'(1)) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                state_d = cpu_vma ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!cpu_vma) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs trail the state by one edge so every bus-facing signal is a clean flop.
    always_comb begin
        cs_n_d  = '1;
        ready_d = (state_q == ST_ACK);
        miss_d  = (state_q == ST_ACK) && !hit_q;
        busy_d  = (state_q != ST_IDLE);
        if ((state_q != ST_IDLE) && hit_q) begin
            cs_n_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            cs_n_q  <= '1;
            ready_q <= 1'b0;
            miss_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            cs_n_q  <= cs_n_d;
            ready_q <= ready_d;
            miss_q  <= miss_d;
            busy_q  <= busy_d;
        end
    end

    assign cs_n      = cs_n_q;
    assign cpu_ready = ready_q;
    assign miss      = miss_q;
    assign busy      = busy_q;

endmodule
